ecc_write_encoder: RTL
======================

# ecc_write_encoder

NB-LDPC (288,256) systematic encoder over GF(8) on the CIM write path, sitting upstream of the array. It is the transmit counterpart of the ECC read buffer. It accepts 256 information symbols in one handshake and computes 32 parity symbols with a dual-diagonal parity chain. It then serialises the 288-symbol codeword into 8 write beats of MACRO×PARALLEL lanes, using the same beat/lane order the read buffer uses to collect ADC symbols.

## Interface
- MACRO, 4, macros written per beat
- PARALLEL, 10, lanes per macro
- SYMBOL_BIT, 3, GF(8) symbol width
- INFO_NUM, 256, information symbols
- CHECK_NUM, 32, parity symbols / check rows
- PERIOD, 8, write beats per codeword
- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- ENABLE  in  1  clock enable; low freezes all state
- BYPASS  in  1  sampled at accept; parity forced to 0, encode phase skipped
- INFO_VALID  in  1  information word present
- INFO_READY  out  1  block can accept a word
- INFO_SYMBOL  in  INFO_NUM×SYMBOL_BIT  information symbols, index i
- WR_VALID  out  1  write beat valid
- WR_READY  in  1  array accepts beat
- WR_BEAT  out  3  beat index p
- WR_SYMBOL  out  MACRO×PARALLEL×SYMBOL_BIT  beat data, [macro j][lane k]

## Operation
- GF(8): primitive polynomial x³+x+1, α=3'b010. Addition is XOR. Multiplication by a constant is a fixed XOR network.
- Each information symbol i has two edges:
  - row1 = i>>3, coefficient α^(i mod 7)
  - row2 = ((i>>3) + 1 + (i&7)) mod 32, coefficient α^((i>>3) mod 7)
  - Each row gets 16 info edges; row1 ≠ row2 always.
- Syndrome s_r = GF-sum of coefficient×info over the edges of row r. It is combinational from the captured info register.
- Parity is dual-diagonal with unit coefficients: p_0 = s_0, p_r = s_r ⊕ p_{r-1}. Every row then satisfies s_r ⊕ p_r ⊕ p_{r-1} = 0 (p_{-1} = 0).
- Codeword index n: n<256 → info n; 256≤n<288 → p_{n-256}.
- Beat mapping: WR_SYMBOL[j][k] at beat p = codeword[p·40 + j·10 + k]. Indices ≥288 (beat 7, slots 8..39) are driven 0.
- FSM states and transitions:
  - IDLE → ENCODE on accept (INFO_VALID && INFO_READY). Accept captures INFO_SYMBOL and BYPASS, and clears the row counter.
  - IDLE → SEND on accept with BYPASS=1.
  - ENCODE: one parity row per cycle, r = 0..31. → SEND after r=31.
  - SEND: beats p = 0..7. The beat advances when WR_VALID && WR_READY. → IDLE after beat 7 transfers.
- INFO_READY = 1 only in IDLE. A new word cannot be captured during ENCODE or SEND.

## Timing
- Reset values:
  - State IDLE.
  - INFO_READY=1 (0 while RST is asserted).
  - WR_VALID=0, WR_BEAT=0, WR_SYMBOL=0.
  - Parity register 0, row counter 0.
- Accept at edge t:
  - p_r registered at edge t+1+r.
  - WR_VALID rises after edge t+32 (first beat visible in cycle t+33).
  - With WR_READY held high, beats occupy 8 consecutive cycles and INFO_READY returns after edge t+40.
- BYPASS: WR_VALID is visible in the cycle after accept; all p_r = 0.
- WR_BEAT/WR_SYMBOL are registered and held stable while WR_VALID=1 and WR_READY=0.
- ENABLE=0: every register holds, including inside ENCODE and SEND. Handshakes are ignored: no accept, no beat advance.
- RST during any state: IDLE on the next edge, and any in-flight codeword is discarded (no partial beats afterwards).
- INFO_VALID asserted in the same cycle as the final beat transfer is not accepted (INFO_READY still 0). It is accepted on the following cycle.

## Structure
- Shared package ecc_pkg holds:
  - GF(8) symbol typedef, the α-power table and gf_mul function
  - row1/row2/coefficient functions
  - MACRO/PARALLEL/PERIOD/INFO_NUM/CHECK_NUM constants, shared with the read buffer and decoder so the H matrix has a single definition
- One sub-module, ecc_syndrome_gen: combinational 256→32 syndrome XOR network.

## Test plan
- All-zero info, BYPASS=0 → all p_r = 0; 8 beats, all lanes 0; INFO_READY back after 40 cycles.
- info[0]=1, rest 0 → s_0 = s_1 = 1; p_0 = 1, p_1..p_31 = 0. Beat 6 slot 16 (n=256) = 1; all other beat-6/7 slots 0.
- info[9]=1 (α², α coefficients) → s_1 = 4, s_3 = 2; p_0 = 0, p_1 = p_2 = 4, p_3..p_31 = 6.
- Random info, WR_READY toggled randomly → every row check s_r ⊕ p_r ⊕ p_{r-1} = 0. Beats are in order, stable while stalled, and none duplicated or dropped.
- BYPASS=1 with random info → info passed through unchanged, parity slots 0, first beat one cycle after accept.
- RST asserted at ENCODE row 10 and again mid-SEND at beat 3 → WR_VALID=0 and INFO_READY=1 after the next edge. A subsequent word encodes correctly. ENABLE=0 for 5 cycles mid-ENCODE delays the output by exactly 5 cycles.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the NB-LDPC (288,256) GF(8) code used on the CIM
// write and read paths: geometry constants, symbol types, GF(8) arithmetic
// and the parity-check matrix edge functions.
package ecc_pkg;

    // Array geometry and code dimensions
    localparam int MACRO      = 4;
    localparam int PARALLEL   = 10;
    localparam int SYMBOL_BIT = 3;
    localparam int INFO_NUM   = 256;
    localparam int CHECK_NUM  = 32;
    localparam int PERIOD     = 8;

    // Derived sizes
    localparam int BEAT_SLOTS = MACRO * PARALLEL;
    localparam int CODE_NUM   = INFO_NUM + CHECK_NUM;
    localparam int PAD_NUM    = PERIOD * BEAT_SLOTS - CODE_NUM;
    localparam int ROW_W      = $clog2(CHECK_NUM);
    localparam int BEAT_W     = $clog2(PERIOD);

    // Symbol and vector types; packed so the flat bit layout of a codeword
    // matches the beat/lane order: symbol n lives at bits [n*3 +: 3]
    typedef logic [SYMBOL_BIT-1:0]           gf8_t;
    typedef gf8_t [INFO_NUM-1:0]             info_vec_t;
    typedef gf8_t [CHECK_NUM-1:0]            check_vec_t;
    typedef gf8_t [MACRO-1:0][PARALLEL-1:0]  beat_t;
    typedef beat_t [PERIOD-1:0]              codeword_t;
    typedef logic [ROW_W-1:0]                row_t;
    typedef logic [BEAT_W-1:0]               beat_idx_t;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_SEND   = 2'd2
    } enc_state_t;

    // Low bits of the primitive polynomial x^3 + x + 1 (x^3 folds to x + 1)
    localparam gf8_t GF_POLY_LOW = 3'b011;

    // alpha^e for e = 0..6 with alpha = x (3'b010); entry 0 is the LSB group
    localparam logic [6:0][SYMBOL_BIT-1:0] ALPHA_POW =
        {3'd5, 3'd7, 3'd6, 3'd3, 3'd4, 3'd2, 3'd1};

    // alpha raised to any non-negative exponent (multiplicative order is 7)
    function automatic gf8_t alpha_pow(input int e);
        return ALPHA_POW[3'(e % 7)];
    endfunction

    // General GF(8) product by shift-and-add with polynomial reduction;
    // with one operand constant this collapses to a small XOR network
    function automatic gf8_t gf_mul(input gf8_t a, input gf8_t b);
        gf8_t acc;
        gf8_t sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < SYMBOL_BIT; k++) begin
            if (b[k]) begin
                acc = acc ^ sh;
            end
            sh = {sh[SYMBOL_BIT-2:0], 1'b0} ^ (sh[SYMBOL_BIT-1] ? GF_POLY_LOW : 3'b000);
        end
        return acc;
    endfunction

    // First check row touched by information symbol i
    function automatic row_t row1(input int i);
        return row_t'(i >> 3);
    endfunction

    // Second check row: offset from the first by 1 + (i & 7), so never equal
    function automatic row_t row2(input int i);
        return row_t'(((i >> 3) + 1 + (i & 7)) % CHECK_NUM);
    endfunction

    // Coefficient on the first edge of information symbol i
    function automatic gf8_t coef1(input int i);
        return alpha_pow(i % 7);
    endfunction

    // Coefficient on the second edge of information symbol i
    function automatic gf8_t coef2(input int i);
        return alpha_pow((i >> 3) % 7);
    endfunction

endpackage

// File: rtl/ecc_syndrome_gen.sv
// Combinational syndrome network: every information symbol contributes its
// two weighted edges to two distinct check rows. All coefficients are
// constants, so each product reduces to a fixed XOR network.
module ecc_syndrome_gen
    import ecc_pkg::*;
(
    input  info_vec_t  info_i,
    output check_vec_t syndrome_o
);

    // Accumulate coefficient*info over both edges of every information symbol
    always_comb begin
        syndrome_o = '0;
        for (int i = 0; i < INFO_NUM; i++) begin
            syndrome_o[row1(i)] = syndrome_o[row1(i)] ^ gf_mul(coef1(i), info_i[i]);
            syndrome_o[row2(i)] = syndrome_o[row2(i)] ^ gf_mul(coef2(i), info_i[i]);
        end
    end

endmodule

// File: rtl/ecc_write_encoder.sv
// Systematic NB-LDPC (288,256) encoder on the CIM write path. Captures a
// whole information word, walks the dual-diagonal parity chain one row per
// cycle, then streams the codeword out as 8 beats of MACRO x PARALLEL lanes
// in the same order the read buffer collects them.
module ecc_write_encoder
    import ecc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  bypass_i,
    input  logic                  info_valid_i,
    output logic                  info_ready_o,
    input  info_vec_t             info_symbol_i,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [BEAT_W-1:0]     wr_beat_o,
    output beat_t                 wr_symbol_o
);

    enc_state_t state_q;
    info_vec_t  info_q;
    logic       bypass_q;
    row_t       row_q;
    check_vec_t parity_q;
    logic       wr_valid_q;
    beat_idx_t  wr_beat_q;
    beat_t      wr_symbol_q;

    check_vec_t syndrome;
    gf8_t       parity_row_d;
    beat_idx_t  beat_sel_d;
    info_vec_t  info_src_d;
    check_vec_t parity_src_d;
    codeword_t  codeword_d;
    beat_t      beat_d;

    logic accept;
    logic beat_xfer;

    ecc_syndrome_gen u_syndrome_gen (
        .info_i     (info_q),
        .syndrome_o (syndrome)
    );

    // Ready is withheld while reset is held so nothing is captured then
    assign info_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept       = enable_i && info_valid_i && info_ready_o;
    assign beat_xfer    = enable_i && wr_valid_q && wr_ready_i;

    assign wr_valid_o  = wr_valid_q;
    assign wr_beat_o   = wr_beat_q;
    assign wr_symbol_o = wr_symbol_q;

    // Next parity on the chain: p_r = s_r ^ p_(r-1), with p_(-1) = 0
    always_comb begin
        parity_row_d = syndrome[row_q];
        if (row_q != '0) begin
            parity_row_d = parity_row_d ^ parity_q[row_q - 1'b1];
        end
    end

    // Assemble the next beat to load: in IDLE it is beat 0 straight from the
    // incoming word (bypass path), otherwise the following beat of the
    // registered codeword; slots past the codeword end read as zero
    always_comb begin
        info_src_d   = (state_q == ST_IDLE) ? info_symbol_i : info_q;
        parity_src_d = ((state_q == ST_IDLE) || bypass_q) ? '0 : parity_q;
        beat_sel_d   = (state_q == ST_SEND) ? beat_idx_t'(wr_beat_q + 1'b1) : '0;
        codeword_d   = {{(PAD_NUM * SYMBOL_BIT){1'b0}}, parity_src_d, info_src_d};
        beat_d       = codeword_d[beat_sel_d];
    end

    // Control FSM with registered write-side outputs; enable low freezes all
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            info_q      <= '0;
            bypass_q    <= 1'b0;
            row_q       <= '0;
            parity_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_beat_q   <= '0;
            wr_symbol_q <= '0;
        end else if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        info_q   <= info_symbol_i;
                        bypass_q <= bypass_i;
                        row_q    <= '0;
                        parity_q <= '0;
                        if (bypass_i) begin
                            state_q     <= ST_SEND;
                            wr_valid_q  <= 1'b1;
                            wr_beat_q   <= '0;
                            wr_symbol_q <= beat_d;
                        end else begin
                            state_q <= ST_ENCODE;
                        end
                    end
                end
                ST_ENCODE: begin
                    parity_q[row_q] <= parity_row_d;
                    row_q           <= row_q + 1'b1;
                    if (row_q == row_t'(CHECK_NUM - 1)) begin
                        state_q     <= ST_SEND;
                        wr_valid_q  <= 1'b1;
                        wr_beat_q   <= '0;
                        wr_symbol_q <= beat_d;
                    end
                end
                ST_SEND: begin
                    if (beat_xfer) begin
                        if (wr_beat_q == beat_idx_t'(PERIOD - 1)) begin
                            state_q     <= ST_IDLE;
                            wr_valid_q  <= 1'b0;
                            wr_beat_q   <= '0;
                            wr_symbol_q <= '0;
                        end else begin
                            wr_beat_q   <= beat_sel_d;
                            wr_symbol_q <= beat_d;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
